// File: rtl/conv_pkg.sv
// Shared window geometry, FSM state encoding and tap indexing for the window fetcher.
package conv_pkg;
  localparam int KERNEL = 3;
  localparam int TAPS   = KERNEL * KERNEL;

  typedef enum logic [2:0] {IDLE, FILL, SHIFT, HOLD, DONE} win_state_t;

  // Flat tap position of (row i, col j) inside the packed window.
  function automatic logic [3:0] tap_idx(input logic [1:0] i, input logic [1:0] j);
    return ({2'b00, i} * 4'(KERNEL)) + {2'b00, j};
  endfunction
endpackage

// File: rtl/win_addr_gen.sv
// Centre/tap counters and RAM address for the window fetcher; 0-cycle address path.
// IMG_WINDOW_ZERO_PAD_EN widens the centre range and flags taps that fall outside the image.
module win_addr_gen
  import conv_pkg::*;
#(
  parameter int N     = 10,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int RW    = $clog2(IMG_H),
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_frame,
  input  logic          ld_row,
  input  logic          ld_shift,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [1:0]    ti,
  output logic [1:0]    tj,
  output logic [N-1:0]  adr,
  output logic          oob,
  output logic          last_col,
  output logic          last_win
);
`ifdef IMG_WINDOW_ZERO_PAD_EN
  localparam logic [RW-1:0] ROW_FIRST = '0;
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = '0;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW+1:0] ROW_LIM   = (RW+2)'(IMG_H);
  localparam logic [CW+1:0] COL_LIM   = (CW+2)'(IMG_W);
`else
  localparam logic [RW-1:0] ROW_FIRST = RW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 2);
  localparam logic [CW-1:0] COL_FIRST = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 2);
`endif
  localparam logic [RW+1:0] ROW_ONE = (RW+2)'(1);
  localparam logic [CW+1:0] COL_ONE = (CW+2)'(1);

  logic [RW+1:0] rr;
  logic [CW+1:0] cc;
  logic [N-1:0]  lin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      ti  <= '0;
      tj  <= '0;
    end else if (ld_frame) begin
      row <= ROW_FIRST;
      col <= COL_FIRST;
      ti  <= '0;
      tj  <= '0;
    end else if (ld_row) begin
      row <= row + 1'b1;
      col <= COL_FIRST;
      ti  <= '0;
      tj  <= '0;
    end else if (ld_shift) begin
      col <= col + 1'b1;
      ti  <= '0;
      tj  <= 2'd2;
    end else if (step) begin
      if (ti == 2'd2) begin
        ti <= '0;
        tj <= tj + 1'b1;
      end else begin
        ti <= ti + 1'b1;
      end
    end
  end

  // Tap (ti,tj) sits at centre + (ti-1, tj-1); a wrap below zero lands above the limit.
  always_comb begin
    rr  = {2'b00, row} + {{RW{1'b0}}, ti} - ROW_ONE;
    cc  = {2'b00, col} + {{CW{1'b0}}, tj} - COL_ONE;
    lin = N'(rr) * N'(IMG_W) + N'(cc);
`ifdef IMG_WINDOW_ZERO_PAD_EN
    oob = (rr >= ROW_LIM) || (cc >= COL_LIM);
    adr = oob ? '0 : lin;
`else
    oob = 1'b0;
    adr = lin;
`endif
  end

  assign last_col = (col == COL_LAST);
  assign last_win = last_col && (row == ROW_LAST);
endmodule

// File: rtl/img_window_fetch.sv
// 3x3 raster window fetch from image RAM: first window 10 cycles after start, then 4 per window.
// Stalls only in HOLD while win_ready is low; IMG_WINDOW_ZERO_PAD_EN enables zero-padded borders.
module img_window_fetch
  import conv_pkg::*;
#(
  parameter int N     = 10,
  parameter int M     = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [N-1:0]             ram_adr,
  input  logic [M-1:0]             ram_dout,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [TAPS*M-1:0]        win_data,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  win_state_t     state, state_nxt;
  logic           ld_frame, ld_row, ld_shift, step;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [1:0]     ti, tj;
  logic [N-1:0]   adr;
  logic           oob, last_col, last_win;
  logic [M-1:0]   pix;
  logic [M-1:0]   tap_q [TAPS];

  win_addr_gen #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H), .RW(RW), .CW(CW)) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_frame (ld_frame),
    .ld_row   (ld_row),
    .ld_shift (ld_shift),
    .step     (step),
    .row      (row),
    .col      (col),
    .ti       (ti),
    .tj       (tj),
    .adr      (adr),
    .oob      (oob),
    .last_col (last_col),
    .last_win (last_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // SHIFT always fetches column 2, so (2,2) marks the final fetch of both FILL and SHIFT.
  always_comb begin
    state_nxt = state;
    ld_frame  = 1'b0;
    ld_row    = 1'b0;
    ld_shift  = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (start) begin
        ld_frame  = 1'b1;
        state_nxt = FILL;
      end
      FILL, SHIFT: begin
        if (ti == 2'd2 && tj == 2'd2) state_nxt = HOLD;
        else                          step      = 1'b1;
      end
      HOLD: if (win_ready) begin
        if (last_win) begin
          state_nxt = DONE;
        end else if (last_col) begin
          ld_row    = 1'b1;
          state_nxt = FILL;
        end else begin
          ld_shift  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == FILL) || (state == SHIFT) || (state == HOLD);
  assign done      = (state == DONE);
  assign win_valid = (state == HOLD);
  assign ram_adr   = busy ? adr : '0;
  assign win_row   = row;
  assign win_col   = col;
  assign pix       = oob ? '0 : ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else if (state == FILL) begin
      tap_q[tap_idx(ti, tj)] <= pix;
    end else if (state == SHIFT) begin
      if (ti == 2'd0) begin
        for (int i = 0; i < KERNEL; i++) begin
          tap_q[tap_idx(2'(i), 2'd0)] <= tap_q[tap_idx(2'(i), 2'd1)];
          tap_q[tap_idx(2'(i), 2'd1)] <= tap_q[tap_idx(2'(i), 2'd2)];
        end
      end
      tap_q[tap_idx(ti, 2'd2)] <= pix;
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < TAPS; k++) win_data[M*k +: M] = tap_q[k];
  end
endmodule
